// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a scan-code FIFO.
//
// ps2_clk and ps2_data are synchronised with two flops each. ps2_clk is then
// filtered so that a level must persist for FILT_LEN samples. Every accepted
// falling edge samples one frame bit: start(0), 8 data bits LSB first, odd
// parity, and stop(1). Valid bytes go into a 2**ADDR_W entry FIFO. A frame
// that stalls mid-way for TIMEOUT cycles is abandoned.
//
// Optional build macro PS2_PREFIX_DECODE_EN: E0/F0 prefix bytes are folded
// into ext/brk flags stored with the following byte instead of being queued.
//
// Ports:
//   clk        system clock
//   clrn       asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   nextdata_n active-low pop request, honoured only while ready=1
//   data       FIFO head byte (0 while the FIFO is empty)
//   ready      FIFO non-empty
//   level      FIFO entry count, 0..2**ADDR_W
//   overflow   sticky: valid frame dropped because the FIFO was full
//   err_parity sticky: odd-parity check failed
//   err_frame  sticky: bad start/stop bit or frame timeout
//   code_ext   head entry carried an E0 prefix (0 without the macro)
//   code_brk   head entry carried an F0 prefix (0 without the macro)
module ps2_rx_fifo #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  output logic [7:0]        data,
  output logic              ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              err_parity,
  output logic              err_frame,
  output logic              code_ext,
  output logic              code_brk
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LW    = ADDR_W + 1;
  localparam int unsigned FCW   = $clog2(FILT_LEN);
  localparam int unsigned TCW   = $clog2(TIMEOUT + 1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int unsigned EW = 10;
`else
  localparam int unsigned EW = 8;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic              clk_s1, clk_s2, dat_s1, dat_s2;
  logic              filt, samp;
  logic [FCW-1:0]    fcnt;
  logic [TCW-1:0]    tcnt;
  logic              tout;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic              start, shift_en, par_en, set_ferr, set_perr, frame_ok;
  logic              wr_req, push, pop, full;
  logic [EW-1:0]     wr_word, head;
  logic [EW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  // Synchronisers idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // fcnt counts differing samples already seen; the FILT_LEN-th one flips
  // the filtered level. samp is a one-cycle pulse after a 1->0 flip.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      filt <= 1'b1;
      fcnt <= '0;
      samp <= 1'b0;
    end else begin
      samp <= 1'b0;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILT_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
        samp <= filt;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  assign tout = (state != IDLE) && (tcnt == TCW'(TIMEOUT));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (tout) begin
      state_n = IDLE;
    end else if (samp) begin
      case (state)
        IDLE:    if (!dat_s2) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    set_ferr = tout;
    set_perr = 1'b0;
    frame_ok = 1'b0;
    if (samp && !tout) begin
      case (state)
        IDLE: begin
          start    = !dat_s2;
          set_ferr = dat_s2;
        end
        DATA:   shift_en = 1'b1;
        PARITY: par_en   = 1'b1;
        STOP: begin
          if (!dat_s2)                set_ferr = 1'b1;
          else if (!(^{shreg, par_bit})) set_perr = 1'b1;
          else                        frame_ok = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (start)         bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg   <= {dat_s2, shreg[7:1]};
      if (par_en)   par_bit <= dat_s2;
      if (state == IDLE || samp || tout) tcnt <= '0;
      else                               tcnt <= tcnt + TCW'(1);
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic pend_ext, pend_brk, is_pfx;

  assign is_pfx  = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign wr_req  = frame_ok && !is_pfx;
  assign wr_word = {pend_ext, pend_brk, shreg};

  // Pending flags are consumed by any non-prefix byte, even one that is
  // then dropped on overflow, so they never attach to an unrelated code.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (set_ferr || set_perr) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (frame_ok) begin
      if (shreg == 8'hE0)      pend_ext <= 1'b1;
      else if (shreg == 8'hF0) pend_brk <= 1'b1;
      else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  assign code_ext = ready ? head[9] : 1'b0;
  assign code_brk = ready ? head[8] : 1'b0;
`else
  assign wr_req   = frame_ok;
  assign wr_word  = shreg;
  assign code_ext = 1'b0;
  assign code_brk = 1'b0;
`endif

  assign ready = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign pop   = ready && !nextdata_n;
  assign push  = wr_req && (!full || pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      if (wr_req && !push) overflow   <= 1'b1;
      if (set_perr)        err_parity <= 1'b1;
      if (set_ferr)        err_frame  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  assign head = mem[rd_ptr];
  assign data = ready ? head[7:0] : '0;

endmodule
